// File: rtl/cfg_loader.sv
// Streams 4*BLOCKS config bytes into per-block field strobes, then checks an XOR checksum byte.
// Strobes trail byte acceptance by one cycle; load_ready drops outside a frame and whenever abort is high.
module cfg_loader #(
   parameter int BLOCKS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] load_data,
   input  logic       load_valid,
   output logic       load_ready,
   output logic [7:0] cfg_in,
   output logic [2:0] cfg_addr,
   output logic       set_x,
   output logic       set_y,
   output logic       set_ab,
   output logic       set_cx,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [2:0] LAST_BLK = 3'(BLOCKS - 1);

   logic [1:0] state;
   logic [2:0] blk_cnt;
   logic [1:0] fld_cnt;
   logic [7:0] acc;
   logic       accept;
   logic       last_byte;

   assign busy       = (state == LOAD) || (state == CHECK);
   assign done       = (state == DONE);
   assign load_ready = busy && !abort;
   assign accept     = load_valid && load_ready;
   assign last_byte  = (fld_cnt == 2'd3) && (blk_cnt == LAST_BLK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         blk_cnt  <= 3'd0;
         fld_cnt  <= 2'd0;
         acc      <= 8'd0;
         cfg_in   <= 8'd0;
         cfg_addr <= 3'd0;
         set_x    <= 1'b0;
         set_y    <= 1'b0;
         set_ab   <= 1'b0;
         set_cx   <= 1'b0;
         error    <= 1'b0;
      end else begin
         set_x  <= 1'b0;
         set_y  <= 1'b0;
         set_ab <= 1'b0;
         set_cx <= 1'b0;

         // abort outranks every other input, including start in IDLE/DONE
         if (abort) begin
            state <= IDLE;
            error <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (start) begin
                     state   <= LOAD;
                     blk_cnt <= 3'd0;
                     fld_cnt <= 2'd0;
                     acc     <= 8'd0;
                     error   <= 1'b0;
                  end
               end

               LOAD: begin
                  if (accept) begin
                     cfg_in   <= load_data;
                     cfg_addr <= blk_cnt;
                     acc      <= acc ^ load_data;
                     case (fld_cnt)
                        2'd0:    set_x  <= 1'b1;
                        2'd1:    set_y  <= 1'b1;
                        2'd2:    set_ab <= 1'b1;
                        default: set_cx <= 1'b1;
                     endcase
                     fld_cnt <= fld_cnt + 2'd1;
                     if (fld_cnt == 2'd3) begin
                        blk_cnt <= (blk_cnt == LAST_BLK) ? 3'd0 : blk_cnt + 3'd1;
                     end
                     if (last_byte) begin
                        state <= CHECK;
                     end
                  end
               end

               default: begin
                  // CHECK: the checksum byte never reaches the fabric
                  if (accept) begin
                     error <= (load_data != acc);
                     state <= DONE;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader: frame table plus hand sequences for abort, restart and reset corners.
module tb_cfg_loader;

   localparam int NB = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] load_data = 8'd0;
   logic       load_valid = 1'b0;
   logic       load_ready;
   logic [7:0] cfg_in;
   logic [2:0] cfg_addr;
   logic       set_x, set_y, set_ab, set_cx;
   logic       busy, done, error;

   cfg_loader #(.BLOCKS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .cfg_in     (cfg_in),
      .cfg_addr   (cfg_addr),
      .set_x      (set_x),
      .set_y      (set_y),
      .set_ab     (set_ab),
      .set_cx     (set_cx),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      bit         throttle;
      bit         mid_start;
      logic [7:0] chk;
      int         abort_after;
      int         exp_strobes;
      bit         exp_done;
      bit         exp_error;
   } vec_t;

   typedef struct packed {
      logic [7:0] d;
      logic [3:0] s;
      logic [2:0] a;
   } exp_t;

   vec_t vecs[6];
   exp_t q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   acc_cnt = 0;
   int   strobe_total = 0;
   bit   pend = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: strobe scoreboard at the falling edge, then step past the rising edge.
   task automatic tick();
      logic [3:0] s;
      exp_t       e;
      @(negedge clk);
      if (rst) begin
         pend = 1'b0;
         q.delete();
      end else begin
         s = {set_x, set_y, set_ab, set_cx};
         chk("strobe_timing", {31'd0, (s != 4'd0)}, {31'd0, pend});
         if (s != 4'd0) begin
            strobe_total++;
            chk("strobe_onehot", $countones(s), 1);
         end
         if (pend) begin
            e = q.pop_front();
            if (s != 4'd0) begin
               chk("strobe_field", {28'd0, s}, {28'd0, e.s});
               chk("strobe_cfg_in", {24'd0, cfg_in}, {24'd0, e.d});
               chk("strobe_cfg_addr", {29'd0, cfg_addr}, {29'd0, e.a});
            end
         end
         pend = 1'b0;
         if (start && !abort && !busy) begin
            acc_cnt = 0;
            q.delete();
         end
         if (load_valid && load_ready) begin
            if (acc_cnt < NB) begin
               e.d = load_data;
               e.s = 4'b1000 >> acc_cnt[1:0];
               e.a = acc_cnt[4:2];
               q.push_back(e);
               pend = 1'b1;
            end
            acc_cnt++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send();
      int n;
      n = 0;
      while (!load_ready && n < 16) begin
         tick();
         n++;
      end
      chk("ready_wait", {31'd0, load_ready}, 32'd1);
      tick();
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
      chk({nm, "_done"}, {31'd0, done}, 32'd0);
      chk({nm, "_error"}, {31'd0, error}, 32'd0);
      chk({nm, "_ready"}, {31'd0, load_ready}, 32'd0);
      chk({nm, "_strobes"}, {28'd0, set_x, set_y, set_ab, set_cx}, 32'd0);
   endtask

   task automatic run_frame(input vec_t v);
      int base;
      int last;
      base = strobe_total;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({v.name, "_start_busy"}, {31'd0, busy}, 32'd1);
      chk({v.name, "_start_done"}, {31'd0, done}, 32'd0);
      chk({v.name, "_start_error"}, {31'd0, error}, 32'd0);
      for (int i = 0; i < NB; i++) begin
         if (i == v.abort_after) begin
            abort = 1'b1;
            load_valid = 1'b1;
            load_data = 8'hEE;
            #1;
            chk({v.name, "_abort_ready"}, {31'd0, load_ready}, 32'd0);
            tick();
            abort = 1'b0;
            chk({v.name, "_abort_busy"}, {31'd0, busy}, 32'd0);
            break;
         end
         load_valid = 1'b1;
         load_data = i[7:0];
         if (v.mid_start && i == 3) start = 1'b1;
         send();
         start = 1'b0;
         if (v.throttle) begin
            load_valid = 1'b0;
            tick();
         end
      end
      if (v.abort_after < 0) begin
         load_valid = 1'b1;
         load_data = v.chk;
         send();
      end else begin
         load_valid = 1'b1;
         load_data = 8'h55;
         tick();
         tick();
      end
      load_valid = 1'b0;
      tick();
      last = (v.abort_after < 0) ? NB - 1 : v.abort_after - 1;
      chk({v.name, "_strobes"}, strobe_total - base, v.exp_strobes);
      chk({v.name, "_done"}, {31'd0, done}, {31'd0, v.exp_done});
      chk({v.name, "_error"}, {31'd0, error}, {31'd0, v.exp_error});
      chk({v.name, "_busy"}, {31'd0, busy}, 32'd0);
      chk({v.name, "_ready"}, {31'd0, load_ready}, 32'd0);
      chk({v.name, "_hold_cfg_in"}, {24'd0, cfg_in}, last);
      chk({v.name, "_hold_cfg_addr"}, {29'd0, cfg_addr}, last / 4);
   endtask

   initial begin
      int base;
      // name, throttle, mid_start, checksum, abort_after, strobes, done, error
      vecs[0] = '{"good",      1'b0, 1'b0, 8'h00, -1, 32, 1'b1, 1'b0};
      vecs[1] = '{"bad_chk",   1'b0, 1'b0, 8'h01, -1, 32, 1'b1, 1'b1};
      vecs[2] = '{"restart",   1'b0, 1'b0, 8'h00, -1, 32, 1'b1, 1'b0};
      vecs[3] = '{"throttled", 1'b1, 1'b1, 8'h00, -1, 32, 1'b1, 1'b0};
      vecs[4] = '{"thr_bad",   1'b1, 1'b0, 8'hFF, -1, 32, 1'b1, 1'b1};
      vecs[5] = '{"abort10",   1'b0, 1'b0, 8'h00, 10, 10, 1'b0, 1'b0};

      #1 rst = 1'b1;
      #2;
      chk_quiet("reset");
      chk("reset_cfg_in", {24'd0, cfg_in}, 32'd0);
      chk("reset_cfg_addr", {29'd0, cfg_addr}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk_quiet("idle");

      foreach (vecs[k]) run_frame(vecs[k]);

      // start together with abort while in DONE with error set
      run_frame(vecs[1]);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk_quiet("start_abort");
      tick();
      chk("start_abort_stays_idle", {31'd0, busy}, 32'd0);

      // reset in the middle of a frame
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         load_valid = 1'b1;
         load_data = 8'h40 + i[7:0];
         send();
      end
      load_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk_quiet("midrst_async");
      chk("midrst_async_cfg_in", {24'd0, cfg_in}, 32'd0);
      tick();
      rst = 1'b0;
      base = strobe_total;
      load_valid = 1'b1;
      load_data = 8'hAA;
      for (int i = 0; i < 3; i++) tick();
      load_valid = 1'b0;
      chk("midrst_no_strobes", strobe_total - base, 32'd0);
      chk_quiet("midrst_after");
      chk("midrst_cfg_in", {24'd0, cfg_in}, 32'd0);
      chk("midrst_cfg_addr", {29'd0, cfg_addr}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule
